// File: rtl/ad7606x_pif_pkg.sv
// Shared types and helpers for the AD7606x parallel-interface responder.
// Optional CRC word is enabled with AD7606X_PIF_CRC_EN (see ad7606x_pif_responder).
package ad7606x_pif_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, READ} pif_state_e;

  localparam logic [7:0] STATUS_TAG = 8'hA5;

  // Channel word k: channel index in the top nibble, frame counter below it.
  // Returned 32 bits wide; callers cast to their bus width (dw <= 32).
  function automatic logic [31:0] chan_word(input int unsigned dw, input logic [3:0] k,
                                            input logic [31:0] fc);
    logic [31:0] mask;
    mask = (32'd1 << (dw - 4)) - 32'd1;
    return ({28'd0, k} << (dw - 4)) | (fc & mask);
  endfunction

  // Status word {A5, frame_cnt[7:0]}, zero-extended to 32 bits.
  function automatic logic [31:0] status_word(input logic [7:0] fc);
    return {16'd0, STATUS_TAG, fc};
  endfunction

endpackage

// File: rtl/ad7606x_pif_edge_det.sv
// One-flop edge detector: registers the input and flags rise/fall against the live level.
module ad7606x_pif_edge_det (
  input  logic sys_clk,
  input  logic rst,
  input  logic sig,
  output logic fall,
  output logic rise
);

  logic sig_d;

  // Previous level; reset high because the strobes it watches are active low.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) sig_d <= 1'b1;
    else     sig_d <= sig;
  end

  assign fall = ~sig & sig_d;
  assign rise = sig & ~sig_d;

endmodule

// File: rtl/ad7606x_pif_responder.sv
// Device-side responder for the AD7606x parallel interface.
// Define AD7606X_PIF_CRC_EN to append an XOR check word to every frame.
module ad7606x_pif_responder
  import ad7606x_pif_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned BUSY_CYCLES  = 20,
  parameter int unsigned CH_CNT_WIDTH = 5
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    status_en,
  input  logic                    cnvst_n,
  input  logic                    cs_n,
  input  logic                    rd_n,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   db_o,
  output logic                    db_t,
  output logic                    data_ready,
  output logic                    first_data,
  output logic [CH_CNT_WIDTH-1:0] ch_count,
  output logic                    frame_done,
  output logic                    overrun
);

  localparam int unsigned FCW = DATA_WIDTH - 4;
  localparam int unsigned BCW = $clog2(BUSY_CYCLES + 1);
`ifdef AD7606X_PIF_CRC_EN
  localparam int unsigned EXTRA_WORDS = 1;
`else
  localparam int unsigned EXTRA_WORDS = 0;
`endif

  logic cnv_fall, cnv_rise_unused, rd_fall_raw, rd_fall, rd_rise;

  pif_state_e              state_q, state_d;
  logic [BCW-1:0]          busy_cnt_q, busy_cnt_d;
  logic [CH_CNT_WIDTH-1:0] ch_count_q, ch_count_d;
  logic [DATA_WIDTH-1:0]   db_q, db_d;
  logic                    data_ready_q, data_ready_d;
  logic                    frame_done_q, frame_done_d;
  logic                    overrun_q, overrun_d;
  logic [FCW-1:0]          frame_cnt_q, frame_cnt_d;
  logic                    status_en_q, status_en_d;
  logic [CH_CNT_WIDTH-1:0] num_words;
  logic [DATA_WIDTH-1:0]   word;
`ifdef AD7606X_PIF_CRC_EN
  logic [DATA_WIDTH-1:0]   crc_q, crc_d;
`endif

  ad7606x_pif_edge_det u_cnv_edge (
    .sys_clk (sys_clk),
    .rst     (rst),
    .sig     (cnvst_n),
    .fall    (cnv_fall),
    .rise    (cnv_rise_unused)
  );

  ad7606x_pif_edge_det u_rd_edge (
    .sys_clk (sys_clk),
    .rst     (rst),
    .sig     (rd_n),
    .fall    (rd_fall_raw),
    .rise    (rd_rise)
  );

  assign rd_fall   = rd_fall_raw & ~cs_n;
  assign num_words = CH_CNT_WIDTH'(NUM_CHANNELS + EXTRA_WORDS) + CH_CNT_WIDTH'(status_en_q);

  // Word presented for the read that is about to be accepted (index = ch_count_q).
  always_comb begin
    word = DATA_WIDTH'(chan_word(DATA_WIDTH, 4'(ch_count_q), 32'(frame_cnt_q)));
    if (status_en_q && ch_count_q == CH_CNT_WIDTH'(NUM_CHANNELS)) begin
      word = DATA_WIDTH'(status_word(8'(frame_cnt_q)));
    end
`ifdef AD7606X_PIF_CRC_EN
    if (ch_count_q == num_words - CH_CNT_WIDTH'(1)) word = crc_q;
`endif
  end

  // Conversion/read framing: next state, counters and per-word strobes.
  always_comb begin
    state_d      = state_q;
    busy_cnt_d   = busy_cnt_q;
    ch_count_d   = ch_count_q;
    db_d         = db_q;
    data_ready_d = 1'b0;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    frame_cnt_d  = frame_cnt_q;
    status_en_d  = status_en_q;
`ifdef AD7606X_PIF_CRC_EN
    crc_d        = crc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cnv_fall) begin
          state_d     = CONVERT;
          busy_cnt_d  = BCW'(BUSY_CYCLES);
          ch_count_d  = '0;
          status_en_d = status_en;
`ifdef AD7606X_PIF_CRC_EN
          crc_d       = '0;
`endif
        end
      end
      CONVERT: begin
        if (cnv_fall) overrun_d = 1'b1;
        busy_cnt_d = busy_cnt_q - BCW'(1);
        if (busy_cnt_q == BCW'(1)) state_d = READ;
      end
      READ: begin
        if (cnv_fall) overrun_d = 1'b1;
        if (ch_count_q == num_words) begin
          // All words delivered: only the trailing read release matters now.
          if (rd_rise) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
            ch_count_d   = '0;
            frame_cnt_d  = frame_cnt_q + FCW'(1);
          end
        end else if (rd_fall) begin
          data_ready_d = 1'b1;
          ch_count_d   = ch_count_q + CH_CNT_WIDTH'(1);
          db_d         = word;
`ifdef AD7606X_PIF_CRC_EN
          crc_d        = crc_q ^ word;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_cnt_q   <= '0;
      ch_count_q   <= '0;
      db_q         <= '0;
      data_ready_q <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_cnt_q  <= '0;
      status_en_q  <= 1'b0;
`ifdef AD7606X_PIF_CRC_EN
      crc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      busy_cnt_q   <= busy_cnt_d;
      ch_count_q   <= ch_count_d;
      db_q         <= db_d;
      data_ready_q <= data_ready_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      frame_cnt_q  <= frame_cnt_d;
      status_en_q  <= status_en_d;
`ifdef AD7606X_PIF_CRC_EN
      crc_q        <= crc_d;
`endif
    end
  end

  assign busy       = (state_q == CONVERT);
  assign db_t       = cs_n | (state_q != READ);
  assign db_o       = db_q;
  assign data_ready = data_ready_q;
  assign first_data = (ch_count_q == CH_CNT_WIDTH'(1));
  assign ch_count   = ch_count_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ad7606x_pif_responder.sv
// Self-checking bench for ad7606x_pif_responder with a frame-level reference model.
module tb_ad7606x_pif_responder;

  localparam int DW   = 16;
  localparam int NCH  = 8;
  localparam int BUSY = 20;
  localparam int CCW  = 5;
`ifdef AD7606X_PIF_CRC_EN
  localparam int CRCW = 1;
`else
  localparam int CRCW = 0;
`endif

  logic           sys_clk = 1'b0;
  logic           rst = 1'b1;
  logic           status_en = 1'b0;
  logic           cnvst_n = 1'b1;
  logic           cs_n = 1'b1;
  logic           rd_n = 1'b1;
  logic           busy, db_t, data_ready, first_data, frame_done, overrun;
  logic [DW-1:0]  db_o;
  logic [CCW-1:0] ch_count;

  int vectors = 0;
  int miscompares = 0;
  int fcnt = 0;   // model frame counter

  ad7606x_pif_responder #(
    .DATA_WIDTH   (DW),
    .NUM_CHANNELS (NCH),
    .BUSY_CYCLES  (BUSY),
    .CH_CNT_WIDTH (CCW)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .status_en  (status_en),
    .cnvst_n    (cnvst_n),
    .cs_n       (cs_n),
    .rd_n       (rd_n),
    .busy       (busy),
    .db_o       (db_o),
    .db_t       (db_t),
    .data_ready (data_ready),
    .first_data (first_data),
    .ch_count   (ch_count),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference word k of a frame, straight from the framing rules.
  function automatic logic [15:0] model_word(input int k, input int f, input bit st,
                                             input logic [15:0] crc);
    if (k < NCH) return 16'((k << 12) | (f % 4096));
    if (st && k == NCH) return 16'(32'hA500 | (f % 256));
    return crc;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_db_o"}, 32'(db_o), 32'd0);
    check({tag, "_db_t"}, 32'(db_t), 32'd1);
    check({tag, "_data_ready"}, 32'(data_ready), 32'd0);
    check({tag, "_first_data"}, 32'(first_data), 32'd0);
    check({tag, "_ch_count"}, 32'(ch_count), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  // Start a conversion and measure how long busy stays high; optional overlapping pulse.
  task automatic do_convert(input bit st, input bit poke);
    int cnt;
    status_en = st;
    cnvst_n = 1'b0;
    tick();
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnvst_n = !(poke && cnt == 5);
      if (cnt == 0) check("db_t_convert", 32'(db_t), 32'd1);
      cnt++;
      tick();
    end
    cnvst_n = 1'b1;
    status_en = $urandom_range(0, 1);  // ignored outside IDLE
    check("busy_len", 32'(cnt), 32'(BUSY));
    if (poke) check("overrun_busy", 32'(overrun), 32'd1);
  endtask

  task automatic read_word(input int k, input int nw, input logic [15:0] w, input bit poke_last);
    int hold;
    for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    rd_n = 1'b0;
    tick();
    check("data_ready", 32'(data_ready), 32'd1);
    check("db_o", 32'(db_o), 32'(w));
    check("ch_count", 32'(ch_count), 32'(k + 1));
    check("first_data", 32'(first_data), 32'(k == 0));
    check("db_t_read", 32'(db_t), 32'd0);
    hold = $urandom_range(0, 2);
    for (int h = 0; h < hold; h++) tick();
    if (hold > 0) check("data_ready_pulse", 32'(data_ready), 32'd0);
    rd_n = 1'b1;
    if (poke_last && k == nw - 1) cnvst_n = 1'b0;
    tick();
    cnvst_n = 1'b1;
    if (k == nw - 1) begin
      check("frame_done", 32'(frame_done), 32'd1);
      check("ch_count_end", 32'(ch_count), 32'd0);
      check("db_t_idle", 32'(db_t), 32'd1);
    end else begin
      check("frame_done_early", 32'(frame_done), 32'd0);
      check("ch_count_hold", 32'(ch_count), 32'(k + 1));
    end
  endtask

  // One frame against the model. csbad_at: index before which a cs_n=1 strobe is tried
  // (-1 = none); abort_after: number of words read before rst (-1 = none).
  task automatic run_frame(input bit st, input int csbad_at, input bit poke, input int abort_after);
    int nw;
    logic [15:0] w, crc;
    do_convert(st, poke);
    nw = NCH + int'(st) + CRCW;
    crc = 16'h0000;
    for (int k = 0; k < nw; k++) begin
      if (k == abort_after) begin
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        fcnt = 0;
        tick();
        return;
      end
      if (k == csbad_at) begin
        cs_n = 1'b1;
        rd_n = 1'b0;
        tick();
        check("cs_hi_data_ready", 32'(data_ready), 32'd0);
        check("cs_hi_ch_count", 32'(ch_count), 32'(k));
        check("cs_hi_db_t", 32'(db_t), 32'd1);
        rd_n = 1'b1;
        tick();
        cs_n = 1'b0;
        tick();
      end
      if (poke && k == 2) begin
        cnvst_n = 1'b0;
        tick();
        cnvst_n = 1'b1;
        tick();
        check("busy_after_read_poke", 32'(busy), 32'd0);
      end
      w = model_word(k, fcnt, st, crc);
      read_word(k, nw, w, poke);
      crc = crc ^ w;
    end
    fcnt = (fcnt + 1) % 4096;
    tick();
    check("frame_done_pulse", 32'(frame_done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // Read strobe while idle is ignored.
    cs_n = 1'b0;
    rd_n = 1'b0;
    tick();
    check("idle_rd_data_ready", 32'(data_ready), 32'd0);
    check("idle_rd_ch_count", 32'(ch_count), 32'd0);
    check("idle_rd_db_t", 32'(db_t), 32'd1);
    rd_n = 1'b1;
    tick();

    // Plain frame, then a status frame (word 9 = A501 in frame 1).
    run_frame(1'b0, -1, 1'b0, -1);
    run_frame(1'b1, -1, 1'b0, -1);

    // Strobes with cs_n high inside READ.
    run_frame(1'($urandom_range(0, 1)), 0, 1'b0, -1);
    run_frame(1'($urandom_range(0, 1)), 5, 1'b0, -1);

    // Randomised frames.
    for (int i = 0; i < 4; i++) run_frame(1'($urandom_range(0, 1)), -1, 1'b0, -1);

    // Overrun: pulses during busy, mid-READ and on the closing edge.
    check("overrun_before", 32'(overrun), 32'd0);
    run_frame(1'($urandom_range(0, 1)), -1, 1'b1, -1);
    check("overrun_sticky", 32'(overrun), 32'd1);
    tick();
    check("no_extra_busy", 32'(busy), 32'd0);

    // Reset after word 3, then a clean frame from frame_cnt 0.
    run_frame(1'b1, -1, 1'b0, 3);
    run_frame(1'b0, -1, 1'b0, -1);
    run_frame(1'b1, -1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ad7606x_pif_responder.md
# ad7606x_pif_responder

Parametrised, synthesizable responder for the AD7606x parallel interface, used as the device-side model in parallel-interface system benches. It samples CNVST_N/RD_N/CS_N from the controller and returns BUSY, a known per-channel data pattern on the DB bus, and per-word sideband flags: data_ready, first_data, ch_count. Channel count, data width, busy time and status-word mode are configurable. It replaces ad-hoc bench logic with a framed conversion/read state machine that handles overruns.

## Interface
- DATA_WIDTH, 16: DB bus width; minimum 8.
- NUM_CHANNELS, 8: analog channels per frame; range 1..16.
- BUSY_CYCLES, 20: sys_clk cycles BUSY stays high per conversion; minimum 1.
- CH_CNT_WIDTH, 5: ch_count width; must hold NUM_CHANNELS+2.
- sys_clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- status_en  in  1  append one status word per frame; sampled only in IDLE.
- cnvst_n  in  1  conversion start, active low.
- cs_n  in  1  chip select, active low.
- rd_n  in  1  read strobe, active low.
- busy  out  1  conversion in progress.
- db_o  out  DATA_WIDTH  read data.
- db_t  out  1  tristate; 1 = bus released.
- data_ready  out  1  one-cycle pulse per accepted read.
- first_data  out  1  high while ch_count == 1.
- ch_count  out  CH_CNT_WIDTH  words read in current frame.
- frame_done  out  1  one-cycle pulse at frame end.
- overrun  out  1  sticky; cleared only by rst.

## Operation
- Inputs are registered once: cnvst_n_d, rd_n_d. cnv_fall = ~cnvst_n & cnvst_n_d. rd_fall = ~rd_n & rd_n_d & ~cs_n. rd_rise = rd_n & ~rd_n_d.
- num_words = NUM_CHANNELS + status_en_l, plus 1 with CRC. status_en_l is status_en latched on IDLE->CONVERT.
- States:
  - IDLE: cnv_fall -> CONVERT; load busy_cnt = BUSY_CYCLES; clear ch_count.
  - CONVERT: busy=1; busy_cnt decrements to 0, then -> READ.
  - READ: each rd_fall pulses data_ready, increments ch_count, and drives db_o with word[ch_count]. The rd_rise after ch_count == num_words pulses frame_done and returns to IDLE with ch_count = 0.
- Channel word k (0-based) = {k[3:0], frame_cnt[DATA_WIDTH-5:0]}.
- Status word = {8'hA5, frame_cnt[7:0]}, zero-extended/truncated to DATA_WIDTH.
- frame_cnt increments at each frame_done and wraps modulo 2^(DATA_WIDTH-4).
- db_t = 0 while cs_n=0 and state=READ; otherwise db_t = 1.
- cnv_fall in CONVERT or READ sets overrun and is otherwise ignored.
- rd_fall in IDLE or CONVERT is ignored: no data_ready, no count.
- Once ch_count == num_words, further rd_fall is ignored.
- rd_fall with cs_n=1 is ignored.
- rst mid-frame: immediate return to IDLE, all outputs to reset values, frame_cnt = 0.

## Timing
- Reset values: busy=0, db_o=0, db_t=1, data_ready=0, first_data=0, ch_count=0, frame_done=0, overrun=0, state IDLE.
- cnvst_n sampled low at edge N (high at N-1): busy high from edge N+1 for exactly BUSY_CYCLES cycles. READ is entered on the edge busy falls.
- rd_n sampled low at edge M (high at M-1): data_ready high, ch_count and db_o updated, all from edge M+1.
- frame_done asserts one cycle after the rd_rise that ends the frame.
- cnv_fall on the same edge as the final rd_rise: the frame closes normally and the conversion is lost. overrun is set.

## Configuration
- AD7606X_PIF_CRC_EN defined: one extra word after the last data/status word. Value = XOR of all preceding words of the frame. num_words grows by 1.
- AD7606X_PIF_CRC_EN undefined: no CRC word, no CRC register.

## Structure
- Package ad7606x_pif_pkg holds:
  - state enum {IDLE, CONVERT, READ};
  - STATUS_TAG = 8'hA5;
  - function computing channel word k.
- Sub-module ad7606x_pif_edge_det (register plus rise/fall pulses), instantiated for cnvst_n and rd_n.

## Test plan
- Defaults, status_en=0, one CNVST_N pulse: busy high for 20 cycles. 8 RD_N strobes -> db_o 0x0000, 0x1000, ..., 0x7000, and data_ready ×8. first_data only on word 1. frame_done once.
- status_en=1, second frame: 9th word = 0xA501. ch_count reaches 9 and then returns to 0.
- CNVST_N pulsed during busy and again during READ: overrun=1, frame completes unchanged, no extra busy.
- RD_N strobes with cs_n=1, and an RD_N strobe in IDLE: no data_ready, db_t stays 1.
- rst asserted after word 3: all outputs at reset values next cycle. The next frame starts at word 0 with frame_cnt=0.
- With AD7606X_PIF_CRC_EN: after 8 words of frame 0, word 9 = 0x0000 ^ 0x1000 ^ ... ^ 0x7000 = 0x0000. Frame 1 CRC = 0x0000 (eight equal frame_cnt terms cancel).
